// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the Pong game-flow sequencer and the rest of the
// display pipeline: frame/key/collision events in, game status out.
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic       start_n;
  logic       miss_left;
  logic       miss_right;
  logic       paddle_hit;
  logic [2:0] state;
  logic       step;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] user_score;
  logic [3:0] cpu_score;
  logic [1:0] speed_level;
  logic       winner;

  modport master (
    output frame_tick, start_n, miss_left, miss_right, paddle_hit,
    input  state, step, ball_reset, serve_dir, user_score, cpu_score,
           speed_level, winner
  );

  modport slave (
    input  frame_tick, start_n, miss_left, miss_right, paddle_hit,
    output state, step, ball_reset, serve_dir, user_score, cpu_score,
           speed_level, winner
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: serve/play/point/game-over control, score
// registers, ball speed level and per-frame movement step generation.
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE      = 9,
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned POINT_FRAMES   = 90,
  parameter int unsigned HITS_PER_LEVEL = 4
) (
  input logic              clk,
  input logic              reset,
  pong_game_ctrl_if.slave  bus
);

  localparam int unsigned MAXF = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned FW   = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam int unsigned HW   = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t      st, st_nx;
  logic [FW-1:0] frame_cnt, frame_cnt_nx;
  logic [HW-1:0] hit_cnt, hit_cnt_nx;
  logic [3:0]  user_q, user_nx, cpu_q, cpu_nx;
  logic [1:0]  speed_q, speed_nx;
  logic        dir_q, dir_nx, winner_q, winner_nx, step_q, step_nx;
  logic [2:0]  key_sync;
  logic        start_evt;
  logic        any_miss, game_won;

  // Two-flop synchronizer for the start key plus one delay flop for edge detect
  always_ff @(posedge clk) begin
    if (reset) key_sync <= '0;
    else       key_sync <= {key_sync[1:0], bus.start_n};
  end

  // Key pressed = synchronized level went from released (1) to pressed (0)
  assign start_evt = key_sync[2] & ~key_sync[1];
  assign any_miss  = bus.miss_left | bus.miss_right;
  assign game_won  = (user_q == 4'(WIN_SCORE)) || (cpu_q == 4'(WIN_SCORE));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      frame_cnt <= '0;
      hit_cnt   <= '0;
      user_q    <= '0;
      cpu_q     <= '0;
      speed_q   <= '0;
      dir_q     <= 1'b0;
      winner_q  <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      st        <= st_nx;
      frame_cnt <= frame_cnt_nx;
      hit_cnt   <= hit_cnt_nx;
      user_q    <= user_nx;
      cpu_q     <= cpu_nx;
      speed_q   <= speed_nx;
      dir_q     <= dir_nx;
      winner_q  <= winner_nx;
      step_q    <= step_nx;
    end
  end

  // Next-state and next-datapath logic; entering SERVE always clears speed and hits
  always_comb begin
    st_nx        = st;
    frame_cnt_nx = frame_cnt;
    hit_cnt_nx   = hit_cnt;
    user_nx      = user_q;
    cpu_nx       = cpu_q;
    speed_nx     = speed_q;
    dir_nx       = dir_q;
    winner_nx    = winner_q;
    step_nx      = 1'b0;
    case (st)
      IDLE, OVER: begin
        if (start_evt) begin
          st_nx        = SERVE;
          user_nx      = '0;
          cpu_nx       = '0;
          dir_nx       = 1'b1;
          winner_nx    = 1'b0;
          speed_nx     = '0;
          hit_cnt_nx   = '0;
          frame_cnt_nx = '0;
        end
      end
      SERVE: begin
        if (bus.frame_tick) begin
          if (frame_cnt == FW'(SERVE_FRAMES - 1)) begin
            st_nx        = PLAY;
            frame_cnt_nx = '0;
          end else begin
            frame_cnt_nx = frame_cnt + FW'(1);
          end
        end
      end
      PLAY: begin
        step_nx = bus.frame_tick & ~any_miss;
        if (bus.miss_left) begin
          cpu_nx = cpu_q + 4'd1;
          dir_nx = 1'b0;
          st_nx  = POINT;
        end else if (bus.miss_right) begin
          user_nx = user_q + 4'd1;
          dir_nx  = 1'b1;
          st_nx   = POINT;
        end else if (bus.paddle_hit) begin
          if (hit_cnt == HW'(HITS_PER_LEVEL - 1)) begin
            hit_cnt_nx = '0;
            if (speed_q != 2'd3) speed_nx = speed_q + 2'd1;
          end else begin
            hit_cnt_nx = hit_cnt + HW'(1);
          end
        end
      end
      POINT: begin
        if (bus.frame_tick) begin
          if (frame_cnt == FW'(POINT_FRAMES - 1)) begin
            frame_cnt_nx = '0;
            if (game_won) begin
              st_nx     = OVER;
              winner_nx = (user_q == 4'(WIN_SCORE));
            end else begin
              st_nx      = SERVE;
              speed_nx   = '0;
              hit_cnt_nx = '0;
            end
          end else begin
            frame_cnt_nx = frame_cnt + FW'(1);
          end
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  assign bus.state       = st;
  assign bus.step        = step_q;
  assign bus.ball_reset  = (st != PLAY);
  assign bus.serve_dir   = dir_q;
  assign bus.user_score  = user_q;
  assign bus.cpu_score   = cpu_q;
  assign bus.speed_level = speed_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed game scenarios with
// randomized event timing, checked every cycle against a rule-level model.
module tb_pong_game_ctrl;

  localparam int WIN = 9;
  localparam int SF  = 60;
  localparam int PF  = 90;
  localparam int HPL = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  pong_game_ctrl_if bus();

  pong_game_ctrl #(
    .WIN_SCORE(WIN),
    .SERVE_FRAMES(SF),
    .POINT_FRAMES(PF),
    .HITS_PER_LEVEL(HPL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: game described as a mode plus plain integer counters
  int m_mode, m_step, m_dir, m_user, m_cpu, m_speed, m_winner, m_frames, m_hits;
  int key_hist[3];
  int p_ft, p_ph, p_ml, p_mr;

  task automatic model_edge();
    int evt;
    int was_play;
    if (reset) begin
      m_mode = 0; m_step = 0; m_dir = 0; m_user = 0; m_cpu = 0;
      m_speed = 0; m_winner = 0; m_frames = 0; m_hits = 0;
      key_hist = '{0, 0, 0};
      return;
    end
    // a press is seen once the key's released->pressed change has crossed the synchronizer
    evt = (key_hist[2] == 1 && key_hist[1] == 0) ? 1 : 0;
    key_hist[2] = key_hist[1];
    key_hist[1] = key_hist[0];
    key_hist[0] = int'(bus.start_n);
    was_play = (m_mode == 2) ? 1 : 0;
    m_step = (was_play == 1 && bus.frame_tick && !bus.miss_left && !bus.miss_right) ? 1 : 0;
    if (m_mode == 0 || m_mode == 4) begin
      if (evt == 1) begin
        m_mode = 1; m_user = 0; m_cpu = 0; m_dir = 1; m_winner = 0;
        m_speed = 0; m_hits = 0; m_frames = 0;
      end
    end else if (m_mode == 1) begin
      if (bus.frame_tick) begin
        m_frames++;
        if (m_frames == SF) begin m_mode = 2; m_frames = 0; end
      end
    end else if (m_mode == 2) begin
      if (bus.miss_left) begin
        m_cpu++; m_dir = 0; m_mode = 3;
      end else if (bus.miss_right) begin
        m_user++; m_dir = 1; m_mode = 3;
      end else if (bus.paddle_hit) begin
        m_hits++;
        if (m_hits == HPL) begin
          m_hits = 0;
          if (m_speed < 3) m_speed++;
        end
      end
    end else if (m_mode == 3) begin
      if (bus.frame_tick) begin
        m_frames++;
        if (m_frames == PF) begin
          m_frames = 0;
          if (m_user == WIN || m_cpu == WIN) begin
            m_mode = 4;
            m_winner = (m_user == WIN) ? 1 : 0;
          end else begin
            m_mode = 1; m_speed = 0; m_hits = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state",       32'(bus.state),       32'(m_mode));
    chk("step",        32'(bus.step),        32'(m_step));
    chk("ball_reset",  32'(bus.ball_reset),  32'(m_mode != 2));
    chk("serve_dir",   32'(bus.serve_dir),   32'(m_dir));
    chk("user_score",  32'(bus.user_score),  32'(m_user));
    chk("cpu_score",   32'(bus.cpu_score),   32'(m_cpu));
    chk("speed_level", 32'(bus.speed_level), 32'(m_speed));
    chk("winner",      32'(bus.winner),      32'(m_winner));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic clear_events();
    bus.frame_tick = 1'b0;
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    bus.paddle_hit = 1'b0;
  endtask

  task automatic rand_events();
    bus.frame_tick = ($urandom_range(99) < p_ft);
    bus.paddle_hit = ($urandom_range(99) < p_ph);
    bus.miss_left  = ($urandom_range(99) < p_ml);
    bus.miss_right = ($urandom_range(99) < p_mr);
  endtask

  task automatic set_policy(input int ft, input int ph, input int ml, input int mr);
    p_ft = ft; p_ph = ph; p_ml = ml; p_mr = mr;
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n = 0;
    while (m_mode != target && n < budget) begin
      rand_events();
      cyc();
      n++;
    end
    clear_events();
    chk(tag, 32'(bus.state), 32'(target));
  endtask

  initial begin
    int starts, steps, prev_state, n, exp_speed;
    reset = 1'b1;
    bus.start_n = 1'b1;
    clear_events();
    set_policy(0, 0, 0, 0);

    // reset state
    repeat (3) cyc();
    reset = 1'b0;
    repeat (5) cyc();
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_ball_reset", 32'(bus.ball_reset), 32'd1);

    // key held low for 100 cycles gives exactly one start
    bus.start_n = 1'b0;
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      prev_state = int'(bus.state);
      cyc();
      if (prev_state == 0 && bus.state == 3'd1) starts++;
    end
    bus.start_n = 1'b1;
    chk("single_start", 32'(starts), 32'd1);
    chk("start_dir", 32'(bus.serve_dir), 32'd1);

    // serve period, ticks at random spacing
    set_policy(40, 0, 30, 30);
    run_until(2, 2000, "serve_to_play");
    chk("play_ball_reset", 32'(bus.ball_reset), 32'd0);

    // five ticks in play give five steps
    steps = 0;
    for (int i = 0; i < 5; i++) begin
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
      if (bus.step) steps++;
      cyc();
      if (bus.step) steps++;
      cyc();
    end
    chk("five_steps", 32'(steps), 32'd5);

    // user scores
    bus.miss_right = 1'b1;
    cyc();
    bus.miss_right = 1'b0;
    chk("user_point", 32'(bus.user_score), 32'd1);
    chk("point_state", 32'(bus.state), 32'd3);
    set_policy(40, 20, 20, 20);
    run_until(1, 2000, "point_to_serve");
    set_policy(40, 0, 0, 0);
    run_until(2, 2000, "serve_to_play2");

    // thirteen paddle hits ramp the speed level, saturating at 3
    for (int k = 1; k <= 13; k++) begin
      bus.paddle_hit = 1'b1;
      cyc();
      bus.paddle_hit = 1'b0;
      exp_speed = (k / HPL > 3) ? 3 : k / HPL;
      chk("speed_hit", 32'(bus.speed_level), 32'(exp_speed));
      n = $urandom_range(2);
      for (int j = 0; j < n; j++) cyc();
    end

    // simultaneous misses with a tick: left wins, no step
    bus.miss_left = 1'b1; bus.miss_right = 1'b1; bus.frame_tick = 1'b1; bus.paddle_hit = 1'b1;
    cyc();
    clear_events();
    chk("dual_cpu", 32'(bus.cpu_score), 32'd1);
    chk("dual_user", 32'(bus.user_score), 32'd1);
    chk("dual_dir", 32'(bus.serve_dir), 32'd0);
    chk("dual_step", 32'(bus.step), 32'd0);
    set_policy(40, 0, 0, 0);
    run_until(1, 2000, "serve_again");
    chk("serve_speed0", 32'(bus.speed_level), 32'd0);

    // computer wins the game
    set_policy(35, 10, 5, 0);
    run_until(4, 60000, "game_over");
    chk("over_winner", 32'(bus.winner), 32'd0);
    chk("over_cpu", 32'(bus.cpu_score), 32'(WIN));

    // restart from game over
    repeat (4) cyc();
    bus.start_n = 1'b0;
    repeat (10) cyc();
    bus.start_n = 1'b1;
    repeat (3) cyc();
    chk("restart_state", 32'(bus.state), 32'd1);
    chk("restart_cpu", 32'(bus.cpu_score), 32'd0);
    chk("restart_winner", 32'(bus.winner), 32'd0);

    // user reaches 3, then reset mid-point
    set_policy(35, 10, 0, 4);
    n = 0;
    while (!(m_mode == 3 && m_user == 3) && n < 20000) begin
      rand_events();
      cyc();
      n++;
    end
    clear_events();
    chk("point_user3", 32'(bus.user_score), 32'd3);
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("abort_state", 32'(bus.state), 32'd0);
    chk("abort_user", 32'(bus.user_score), 32'd0);
    chk("abort_ball_reset", 32'(bus.ball_reset), 32'd1);

    // collision events in idle change nothing
    set_policy(50, 50, 50, 50);
    for (int i = 0; i < 30; i++) begin
      rand_events();
      cyc();
    end
    clear_events();
    chk("idle_state", 32'(bus.state), 32'd0);
    chk("idle_scores", 32'({bus.user_score, bus.cpu_score}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-flow sequencer for the 1024x768 Pong display pipeline. It owns the serve/play/point/game-over state machine, the user and computer score registers, and the ball speed level. It issues one movement step per frame to the paddle/ball update logic, and it holds the ball at centre between rallies. It consumes a per-frame tick from the VGA timing generator and event pulses from the ball/paddle collision logic.

Parameters:
WIN_SCORE, 9, score that ends the game (1..15)
SERVE_FRAMES, 60, frames the ball is held at centre before a rally starts (>=1)
POINT_FRAMES, 90, frames of pause after a point is scored (>=1)
HITS_PER_LEVEL, 4, paddle hits per speed-level increment (>=1)

Ports:
clk  in  1  pixel clock
reset  in  1  reset, synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame, start of vertical blank
start_n  in  1  start key, active-low, asynchronous to clk
miss_left  in  1  one-cycle pulse: ball left the left edge (computer scores)
miss_right  in  1  one-cycle pulse: ball left the right edge (user scores)
paddle_hit  in  1  one-cycle pulse: ball bounced off either paddle
state  out  3  0=IDLE 1=SERVE 2=PLAY 3=POINT 4=OVER
step  out  1  one-cycle movement enable for the paddle/ball update logic
ball_reset  out  1  hold ball at (512,384) and paddles at centre
serve_dir  out  1  initial ball direction; 0=left, 1=right
user_score  out  4  user points, binary
cpu_score  out  4  computer points, binary
speed_level  out  2  ball speed level 0..3
winner  out  1  valid in OVER; 1=user, 0=computer

Behaviour:
- Reset (sync): state=IDLE; step=0, ball_reset=1, serve_dir=0, scores=0, speed_level=0, winner=0. Frame counter, hit counter and synchronizer are cleared. Reset mid-game aborts the game immediately, with no partial score update.
- start_n passes through a 2-flop synchronizer plus a falling-edge detector to produce start_evt, a 1 cycle pulse. Holding the key low gives exactly one event.
- All registered outputs update on the clk edge after the causing input is sampled, so latency is 1 cycle unless stated otherwise.
- IDLE: ball_reset=1. start_evt -> SERVE; scores cleared to 0; serve_dir=1.
- SERVE: ball_reset=1; speed_level and hit counter cleared on entry. The frame counter increments on each frame_tick. When frame_tick arrives with counter==SERVE_FRAMES-1, go to PLAY and clear the counter.
- PLAY: ball_reset=0.
  - step=1 in the cycle after each frame_tick, unless a miss is accepted in the tick cycle.
  - paddle_hit increments the hit counter. When the counter reaches HITS_PER_LEVEL it clears, and speed_level increments, saturating at 3.
- Misses in PLAY:
  - miss_left: cpu_score+1, serve_dir=0, go to POINT.
  - miss_right: user_score+1, serve_dir=1, go to POINT.
  - miss_left and miss_right in the same cycle: only miss_left is taken.
  - paddle_hit in the same cycle as a miss is ignored.
- POINT: ball_reset=1, step=0. Count POINT_FRAMES frame_ticks.
  - At expiry with either score == WIN_SCORE: go to OVER. winner=1 if user_score==WIN_SCORE, else 0.
  - At expiry otherwise: go to SERVE.
- OVER: ball_reset=1; scores and winner hold. start_evt -> SERVE; scores cleared; serve_dir=1; winner=0.
- miss_*, paddle_hit and frame_tick-driven step are ignored outside PLAY. start_evt is ignored in SERVE, PLAY and POINT.
- Scores never exceed WIN_SCORE, because the game leaves PLAY on every point. Frame counter width is ceil(log2(max(SERVE_FRAMES,POINT_FRAMES))).
- Undefined state encodings (5..7) recover to IDLE on the next clock.

Test Plan:
- Reset, then start_n low for 100 cycles -> exactly one start_evt; state goes 0->1; scores=0; serve_dir=1; after 60 frame_ticks state=2 and ball_reset=0.
- In PLAY, 5 frame_ticks -> exactly 5 step pulses, each 1 cycle after its tick. Inject miss_right -> user_score=1, state=3, no further step. After 90 ticks -> state=1.
- In PLAY, 13 paddle_hit pulses -> speed_level 0,0,0,1 ... 3; stays 3 after the 12th hit. Next SERVE -> speed_level=0.
- miss_left and miss_right asserted in the same cycle, coincident with frame_tick -> cpu_score+1, user_score unchanged, serve_dir=0, no step.
- Computer scores 9 points -> after the final POINT delay state=4, winner=0, cpu_score=9. start_evt -> state=1, scores=0, winner=0.
- Assert reset for 1 cycle mid-POINT with user_score=3 -> next cycle state=0, scores=0, ball_reset=1. miss/hit pulses in IDLE leave all outputs unchanged.
